insere_numero: RTL
==================

Name: insere_numero

Overview:
- Write-side counterpart to the position-check stage; owns the player board register `sudokuJogador`.
- After the control FSM has validated an empty cell, this block:
  - checks the requested digit against the cell's row, column and 3x3 box, one cell per clock;
  - writes the digit into the board only if there is no conflict;
  - reports accept or reject to the FSM.
- It also loads the initial puzzle into the board.

Parameters:
- N_CELULAS, 81, cells in board (fixed 9x9; not meant to be overridden).
- BITS_CELULA, 4, bits per cell.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- carregar  input  1  load sudokuInicial into the board (honoured only in OCIOSO).
- sudokuInicial  input  [0:323]  puzzle image; same packing as the board.
- enable  input  1  level request from the FSM; held high for the whole operation.
- regLinha  input  4  target row, 1..9.
- regColuna  input  4  target column, 1..9.
- regNumero  input  4  digit to insert, 1..9.
- sudokuJogador  output  [0:323]  board register.
- saidaInsercao  output  2  00 idle/busy, 11 written, 10 rejected.
- ocupado  output  1  high in VERIFICA/ESCREVE.

Behaviour:
- Board packing: cell (l,c) occupies `sudokuJogador[(l-1)*36+(c-1)*4 +: 4]`. The lowest index is the MSB of the digit. Value 0 means empty.
- Reset (async, rstn=0):
  - board = all zeros, saidaInsercao = 00, ocupado = 0;
  - state = OCIOSO, scan counter = 0, latched operands = 0.
- States: OCIOSO, VERIFICA, ESCREVE, CONCLUIDO.
- OCIOSO:
  - carregar=1 and enable=0: board <= sudokuInicial on that edge.
  - enable=1 (has priority over carregar): latch linha/coluna/numero and set counter k=0.
    - If linha or coluna is outside 1..9, numero is outside 1..9, or the target cell is non-zero: go to CONCLUIDO with saida=10.
    - Otherwise go to VERIFICA.
- VERIFICA:
  - One compare per edge, k = 0..26.
  - Cell compared at step k:
    - k 0..8: (linha, k+1).
    - k 9..17: (k-8, coluna).
    - k 18..26: (br+(k-18)/3, bc+(k-18)%3), where br = ((linha-1)/3)*3+1 and bc = ((coluna-1)/3)*3+1.
  - Cell == numero: go to CONCLUIDO with saida=10 on that edge.
  - k == 26 with no match: go to ESCREVE.
  - Target cell is never a false hit, because it was checked to be zero.
- ESCREVE: write numero into the target cell; go to CONCLUIDO with saida=11.
- CONCLUIDO: hold saida and the board until enable=0, then go to OCIOSO with saida=00.
- Latency for a clean insert: saida=11 is visible after the 29th rising edge with enable high. Edge 1 latches, edges 2..28 scan, edge 29 writes.
- Latency for a conflict at step k: saida=10 after edge k+2.
- enable dropping in VERIFICA or ESCREVE: abort. No write, OCIOSO, saida=00 on the next edge.
- carregar outside OCIOSO: ignored. It is not queued.
- Inputs latched on entry are authoritative. Changes to regLinha, regColuna or regNumero mid-operation have no effect.
- Reset mid-operation: immediate return to reset values, including clearing the board.
- Only the target cell's 4 bits may change on a write; all other 320 bits stay stable.

Test Plan:
- Reset, then carregar=1 with a puzzle where cell (1,1)=5 -> sudokuJogador[0+:4]=4'd5, saida=00.
- Empty board, enable with (5,5,7) held -> saida=11 exactly at the 29th edge, cell (5,5)=7, every other bit 0, ocupado low afterwards.
- Board with (5,9)=7, insert (5,1,7) -> saida=10 after edge 10 (k=8), cell (5,1) still 0. Repeat with (9,1)=7 -> reject at k=17. Repeat with (6,3)=7 and target (4,1) -> reject at box step.
- Illegal operands (0,3,4), (3,3,10), and an occupied target -> saida=10 after the first edge, board unchanged.
- enable dropped at scan step 10 of a valid insert -> saida=00 next edge, no write. A fresh request afterwards completes normally.
- rstn pulsed low mid-VERIFICA -> board cleared, outputs zero asynchronously. carregar asserted in CONCLUIDO -> board unchanged.

Source files
------------

// File: rtl/insere_numero.sv
// Write side of the player board: scans the target's row, column and 3x3 box one cell per clock
// and stores the digit only when no conflict is found. Also loads the initial puzzle.
module insere_numero #(
    parameter int N_CELULAS   = 81,
    parameter int BITS_CELULA = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              carregar,
    input  logic [0:N_CELULAS*BITS_CELULA-1]  sudokuInicial,
    input  logic                              enable,
    input  logic [3:0]                        regLinha,
    input  logic [3:0]                        regColuna,
    input  logic [3:0]                        regNumero,
    output logic [0:N_CELULAS*BITS_CELULA-1]  sudokuJogador,
    output logic [1:0]                        saidaInsercao,
    output logic                              ocupado
);

    localparam int         W_TAB      = N_CELULAS * BITS_CELULA;
    localparam logic [1:0] SAIDA_NADA = 2'b00;
    localparam logic [1:0] SAIDA_OK   = 2'b11;
    localparam logic [1:0] SAIDA_REJ  = 2'b10;
    localparam logic [4:0] K_ULTIMO   = 5'd26;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        VERIFICA  = 2'd1,
        ESCREVE   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [4:0]       k_q, k_d;
    logic [3:0]       linha_q, linha_d;
    logic [3:0]       coluna_q, coluna_d;
    logic [3:0]       numero_q, numero_d;
    logic [0:W_TAB-1] tab_q, tab_d;
    logic [1:0]       saida_q, saida_d;

    // Bit offset of cell (l,c), both 1-based; cell MSB sits at the lowest index.
    function automatic int indice(input logic [3:0] l, input logic [3:0] c);
        return (int'(l) - 1) * 36 + (int'(c) - 1) * 4;
    endfunction

    function automatic logic [3:0] celula(input logic [0:W_TAB-1] t,
                                          input logic [3:0] l, input logic [3:0] c);
        return t[indice(l, c) +: 4];
    endfunction

    logic       ops_ok;
    logic [3:0] alvo_atual;

    always_comb begin
        ops_ok = (regLinha  >= 4'd1) && (regLinha  <= 4'd9) &&
                 (regColuna >= 4'd1) && (regColuna <= 4'd9) &&
                 (regNumero >= 4'd1) && (regNumero <= 4'd9);
        alvo_atual = 4'd0;
        if (ops_ok) begin
            alvo_atual = celula(tab_q, regLinha, regColuna);
        end
    end

    // Scan address: k 0..8 walks the row, 9..17 the column, 18..26 the box.
    logic [3:0] box_l, box_c;
    logic [3:0] scan_l, scan_c;
    logic [4:0] j;
    logic [3:0] scan_val;

    always_comb begin
        box_l  = ((linha_q  - 4'd1) / 4'd3) * 4'd3 + 4'd1;
        box_c  = ((coluna_q - 4'd1) / 4'd3) * 4'd3 + 4'd1;
        scan_l = linha_q;
        scan_c = coluna_q;
        j      = 5'd0;
        if (k_q < 5'd9) begin
            scan_c = k_q[3:0] + 4'd1;
        end else if (k_q < 5'd18) begin
            scan_l = 4'(k_q - 5'd8);
        end else begin
            j      = k_q - 5'd18;
            scan_l = box_l + 4'(j / 5'd3);
            scan_c = box_c + 4'(j % 5'd3);
        end
        scan_val = celula(tab_q, scan_l, scan_c);
    end

    always_comb begin
        estado_d = estado_q;
        k_d      = k_q;
        linha_d  = linha_q;
        coluna_d = coluna_q;
        numero_d = numero_q;
        tab_d    = tab_q;
        saida_d  = saida_q;

        case (estado_q)
            OCIOSO: begin
                saida_d = SAIDA_NADA;
                if (enable) begin
                    linha_d  = regLinha;
                    coluna_d = regColuna;
                    numero_d = regNumero;
                    k_d      = 5'd0;
                    if (!ops_ok || (alvo_atual != 4'd0)) begin
                        estado_d = CONCLUIDO;
                        saida_d  = SAIDA_REJ;
                    end else begin
                        estado_d = VERIFICA;
                    end
                end else if (carregar) begin
                    tab_d = sudokuInicial;
                end
            end

            VERIFICA: begin
                if (!enable) begin
                    estado_d = OCIOSO;
                    saida_d  = SAIDA_NADA;
                end else if (scan_val == numero_q) begin
                    estado_d = CONCLUIDO;
                    saida_d  = SAIDA_REJ;
                end else if (k_q == K_ULTIMO) begin
                    estado_d = ESCREVE;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end

            ESCREVE: begin
                if (!enable) begin
                    estado_d = OCIOSO;
                    saida_d  = SAIDA_NADA;
                end else begin
                    tab_d[indice(linha_q, coluna_q) +: 4] = numero_q;
                    estado_d = CONCLUIDO;
                    saida_d  = SAIDA_OK;
                end
            end

            CONCLUIDO: begin
                if (!enable) begin
                    estado_d = OCIOSO;
                    saida_d  = SAIDA_NADA;
                end
            end

            default: begin
                estado_d = OCIOSO;
                saida_d  = SAIDA_NADA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            estado_q <= OCIOSO;
            k_q      <= 5'd0;
            linha_q  <= 4'd0;
            coluna_q <= 4'd0;
            numero_q <= 4'd0;
            tab_q    <= '0;
            saida_q  <= SAIDA_NADA;
        end else begin
            estado_q <= estado_d;
            k_q      <= k_d;
            linha_q  <= linha_d;
            coluna_q <= coluna_d;
            numero_q <= numero_d;
            tab_q    <= tab_d;
            saida_q  <= saida_d;
        end
    end

    assign sudokuJogador = tab_q;
    assign saidaInsercao = saida_q;
    assign ocupado       = (estado_q == VERIFICA) || (estado_q == ESCREVE);

endmodule
